// File: rtl/key_square_core.sv
// Computes key_out = msg_in^2 mod P with a bit-serial, MSB-first interleaved
// modular multiplier: one operand bit per cycle, W cycles per job.
module key_square_core #(
    parameter int             W = 256,
    parameter logic [W-1:0]   P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [31:0]   start_reg,
    input  logic [W-1:0]  msg_in,
    output logic [W-1:0]  key_out,
    output logic          done,
    output logic          busy
);

    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REDUCE,
        ST_MUL,
        ST_FINISH,
        ST_DONE
    } state_t;

    state_t          state, state_d;
    logic            start_q;
    logic            start_edge;
    logic [CW-1:0]   counter;
    logic [W-1:0]    a;
    logic [W-1:0]    r;

    logic [W+1:0]    p_ext;
    logic [W+1:0]    dbl;
    logic [W+1:0]    dbl_red;
    logic [W+1:0]    sum;
    logic [W+1:0]    sum_red;
    logic [W-1:0]    msg_red;

    // Only bit 0 of START is meaningful; both reductions keep their results below P,
    // so the top two bits of sum_red are always zero.
    logic            unused_bits;
    assign unused_bits = ^{start_reg[31:1], sum_red[W+1:W]};

    assign start_edge = start_reg[0] & ~start_q;
    assign busy       = (state == ST_REDUCE) || (state == ST_MUL);
    assign done       = (state == ST_DONE);

    // One iteration: R <- (2R mod P + A[i]*A) mod P, two add/compare stages.
    always_comb begin
        p_ext   = {2'b00, P};
        dbl     = {1'b0, r, 1'b0};
        dbl_red = (dbl >= p_ext) ? dbl - p_ext : dbl;
        sum     = a[counter] ? dbl_red + {2'b00, a} : dbl_red;
        sum_red = (sum >= p_ext) ? sum - p_ext : sum;
        msg_red = (msg_in >= P) ? msg_in - P : msg_in;
    end

    // NOTE: every combinational output gets a default before the case so no path
    // through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:   if (start_edge) state_d = ST_REDUCE;
            ST_REDUCE: state_d = ST_MUL;
            ST_MUL:    if (counter == '0) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_DONE;
            ST_DONE:   if (!start_reg[0]) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            counter <= '0;
            a       <= '0;
            r       <= '0;
            key_out <= '0;
        end else begin
            state   <= state_d;
            start_q <= start_reg[0];
            case (state)
                ST_REDUCE: begin
                    a       <= msg_red;
                    r       <= '0;
                    counter <= CW'(W - 1);
                end
                ST_MUL: begin
                    r <= sum_red[W-1:0];
                    if (counter != '0) counter <= counter - 1'b1;
                end
                ST_FINISH: key_out <= r;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_square_core.sv
// Directed bench for key_square_core: hand-computed squares mod P, start-edge
// protocol, latency, mid-job reset, plus a few vectors against a wide-arithmetic model.
module tb_key_square_core;

    localparam logic [255:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam int LAT   = 259;  // edges from the sampling edge up to and including the one raising done
    localparam int LIMIT = 400;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic [31:0]   start_reg = '0;
    logic [255:0]  msg_in = '0;
    logic [255:0]  key_out;
    logic          done;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    key_square_core dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start_reg (start_reg),
        .msg_in    (msg_in),
        .key_out   (key_out),
        .done      (done),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Raise START, wait for done, check latency/result, drop START and check done falls.
    task automatic run_job(input string tag, input logic [255:0] msg, input logic [255:0] exp);
        int n;
        @(negedge Clk);
        msg_in    = msg;
        start_reg = 32'hFFFF_FFFF;  // upper bits must be ignored
        n = 0;
        for (int i = 1; i <= LIMIT; i++) begin
            @(posedge Clk); #1;
            if (i == 1)   check({tag, " busy_after_start"}, 256'(busy), 256'd1);
            if (i == LAT - 1) check({tag, " finish_busy_done"}, 256'({busy, done}), 256'd0);
            if (done) begin n = i; break; end
        end
        check({tag, " latency"}, 256'(n), 256'(LAT));
        check({tag, " key_out"}, key_out, exp);
        @(negedge Clk);
        start_reg = '0;
        @(posedge Clk); #1;
        check({tag, " done_fall"}, 256'(done), 256'd0);
    endtask

    initial begin
        logic [255:0] m;
        logic [511:0] sq;
        int n;

        // Reset state
        #12;
        check("reset key_out", key_out, 256'd0);
        check("reset done_busy", 256'({done, busy}), 256'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("idle busy", 256'(busy), 256'd0);

        run_job("zero",  256'd0, 256'd0);
        run_job("two",   256'd2, 256'd4);
        run_job("one",   256'd1, 256'd1);
        run_job("p_m1",  P - 256'd1, 256'd1);
        run_job("p",     P, 256'd0);
        run_job("p_p5",  P + 256'd5, 256'd25);
        run_job("all1",  {256{1'b1}}, 256'h1_000007A0_000E8900);

        // START held high after completion: done stays, no restart
        @(negedge Clk);
        msg_in    = 256'd5;
        start_reg = 32'd1;
        n = 0;
        for (int i = 1; i <= LIMIT; i++) begin
            @(posedge Clk); #1;
            if (done) begin n = i; break; end
        end
        check("hold latency", 256'(n), 256'(LAT));
        repeat (20) @(posedge Clk);
        #1;
        check("hold done_busy", 256'({done, busy}), 256'b10);
        check("hold key_out", key_out, 256'd25);
        @(negedge Clk);
        start_reg = '0;
        repeat (5) @(posedge Clk);
        #1;
        check("hold no_restart", 256'({done, busy}), 256'd0);

        // Second START pulse and msg_in change during MUL are ignored
        @(negedge Clk);
        msg_in    = 256'd6;
        start_reg = 32'd1;
        n = 0;
        for (int i = 1; i <= LIMIT; i++) begin
            @(posedge Clk); #1;
            if (i == 50) start_reg = '0;
            if (i == 60) start_reg = 32'd1;
            if (i == 70) msg_in = 256'd11;
            if (done) begin n = i; break; end
        end
        check("repulse latency", 256'(n), 256'(LAT));
        check("repulse key_out", key_out, 256'd36);
        @(negedge Clk);
        start_reg = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("repulse idle", 256'({done, busy}), 256'd0);

        // Reset mid-MUL (iteration 100) clears outputs asynchronously
        @(negedge Clk);
        msg_in    = 256'd7;
        start_reg = 32'd1;
        repeat (102) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("midreset key_out", key_out, 256'd0);
        check("midreset done_busy", 256'({done, busy}), 256'd0);
        @(negedge Clk);
        start_reg = '0;
        Reset_n   = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("postreset busy", 256'(busy), 256'd0);
        run_job("three", 256'd3, 256'd9);

        // A few wide vectors against msg^2 mod P
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 8; k++) m[k*32 +: 32] = $urandom;
            sq = {256'd0, m} * {256'd0, m};
            sq = sq % {256'd0, P};
            run_job($sformatf("rand%0d", j), m, sq[255:0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_square_core.md
# key_square_core

Downstream consumer of the Avalon register file: takes the 256-bit MSG_IN value (registers 0-7) and the START register (30), and computes KEY_OUT = MSG_IN² mod P with a bit-serial interleaved modular multiplier. It returns the 256-bit result and the DONE flag to the register readback path, for words 8-15 and register 31. Software protocol: write MSG_IN, write START=1, poll DONE, read KEY_OUT, write START=0.

## Interface
- W, 256: operand/result width.
- P, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F: modulus (secp256k1 prime). P[W-1] must be 1.
- Clk  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- start_reg  input  32  START register contents; only bit 0 is used, bits 31:1 are ignored.
- msg_in  input  W  {D7,D6,…,D0}; D0 is the least-significant word.
- key_out  output  W  result, split into KEY_OUT words 8-15, least-significant word in register 8.
- done  output  1  result valid; mirrored into DONE register bit 0.
- busy  output  1  high in REDUCE and MUL.

## Operation
- Reset (Reset_n=0, asynchronous) sets:
  - state=IDLE, key_out=0, done=0, busy=0, start_q=0, counter=0, accumulator R=0, operand A=0.
- start_q registers start_reg[0] every cycle, in every state. start_edge = start_reg[0] & ~start_q.
- IDLE: on start_edge go to REDUCE. A level held high never retriggers.
- REDUCE, 1 cycle:
  - A <= (msg_in >= P) ? msg_in − P : msg_in. One subtraction suffices because P > 2^(W−1).
  - R <= 0, counter <= W−1, go to MUL.
- MUL, W cycles, MSB-first, one iteration per cycle, i = counter:
  - T = 2R; if T >= P then T −= P.
  - If A[i], T += A; if T >= P then T −= P.
  - R <= T. Intermediates are W+2 bits wide; R always stays < P.
  - When counter=0, go to FINISH; otherwise decrement counter.
- FINISH: key_out <= R, done <= 1, go to DONE.
  - key_out is only written here. It holds its value through IDLE until the next FINISH.
- DONE:
  - Stay while start_reg[0]=1.
  - When start_reg[0]=0: done <= 0, go to IDLE.
- msg_in is sampled only in REDUCE. Later changes to msg_in do not affect the running operation.
- start_edge in REDUCE, MUL, FINISH or DONE is ignored. It is not queued.
- If start_reg[0] falls during MUL, the operation completes normally. done then asserts for at least one cycle (FINISH→DONE→IDLE).
- A new job requires START to go 0→1 again after DONE has returned to IDLE.

## Timing
- Edge k samples start_edge in IDLE. After edge k: state=REDUCE, busy=1.
- After edge k+1: MUL, counter=255.
- Edges k+2 … k+257 perform the 256 iterations.
- After edge k+257: FINISH, busy=0.
- After edge k+258: key_out valid and done=1.
- Total: done rises 258 cycles after the sampling edge.
- busy and done are never high simultaneously.
- done falls on the first edge that sees start_reg[0]=0 in DONE.
- Reset_n asserted in any state clears all outputs immediately (asynchronously). After deassertion the block is in IDLE.
  - If start_reg[0] is still 1 after deassertion, start_q takes 1 on the first edge. Because start_q resets to 0, that first edge can still detect an edge; this is the required behaviour.
- The critical path is two W+2-bit add/compare stages per cycle; no multicycle paths are allowed.

## Test plan
- msg_in=0, start pulse -> after 258 cycles done=1, key_out=0. START←0 -> done=0 next cycle.
- msg_in=2 -> key_out=4. msg_in=1 -> key_out=1.
- msg_in=P−1 -> key_out=1. msg_in=P -> key_out=0 (REDUCE path).
- msg_in=2^256−1 (reduces to 0x1_000003D0) -> key_out=0x1_000007A0_000E8900.
- START held at 1 after completion -> exactly one job. done stays 1 with no restart.
- A second 0→1 START pulse during MUL is ignored; the result is unchanged.
- Reset_n pulsed low at iteration 100 -> key_out=0, done=0, busy=0 immediately. A subsequent job with msg_in=3 returns 9.
- Random msg_in, ≥1000 jobs, compared against a reference model of msg² mod P.
